// File: rtl/instr_prefetch_queue_pkg.sv
// Shared definitions for the fetch stage: word width, the value shown when the queue
// is empty, and the default reset fetch address.
package instr_prefetch_queue_pkg;
  localparam int              WORD_W         = 16;
  localparam logic [15:0]     NOP_INSTR      = 16'h0000;
  localparam logic [15:0]     RST_PC_DEFAULT = 16'h0000;
endpackage

// File: rtl/instr_prefetch_queue_pq_fifo_mem.sv
// Prefetch queue storage: DEPTH entries of {pc, instr}. Synchronous write, combinational read.
// The array has no reset; entry validity comes only from the pointers in the top.
module pq_fifo_mem
  import instr_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wrEn,
  input  logic [AW-1:0]         wrAddr,
  input  logic [2*WORD_W-1:0]   wrData,
  input  logic [AW-1:0]         rdAddr,
  output logic [2*WORD_W-1:0]   rdData
);

  logic [2*WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/instr_prefetch_queue.sv
// Fetch stage feeding decode. It drives the instruction memory address, queues each
// fetched word with its PC, absorbs decode stalls and flushes on redirect.
module instr_prefetch_queue
  import instr_prefetch_queue_pkg::*;
#(
  parameter int                 DEPTH   = 4,
  parameter logic [WORD_W-1:0]  PC_STEP = 16'd1,
  parameter logic [WORD_W-1:0]  RST_PC  = RST_PC_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [15:0]               imem_addr,
  output logic                      imem_req,
  input  logic                      imem_ready,
  input  logic [15:0]               imem_rdata,
  input  logic                      redirect,
  input  logic [15:0]               redirect_pc,
  input  logic                      dec_stall,
  output logic                      instr_valid,
  output logic [15:0]               instr_out,
  output logic [15:0]               instr_pc,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic [15:0]               fetch_count
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]          rdPtr, wrPtr;
  logic [WORD_W-1:0]    fetchPc;
  logic [WORD_W-1:0]    fetchCount;
  logic                 full, empty, pop, push;
  logic [2*WORD_W-1:0]  headEntry;

  // The extra pointer bit tells a full queue apart from an empty one.
  assign empty = (rdPtr == wrPtr);
  assign full  = (rdPtr[AW-1:0] == wrPtr[AW-1:0]) && (rdPtr[AW] != wrPtr[AW]);

  assign pop      = instr_valid & ~dec_stall & ~redirect;
  assign imem_req = ~redirect & (~full | pop);
  assign push     = imem_req & imem_ready;

  pq_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk    (clk),
    .wrEn   (push),
    .wrAddr (wrPtr[AW-1:0]),
    .wrData ({fetchPc, imem_rdata}),
    .rdAddr (rdPtr[AW-1:0]),
    .rdData (headEntry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr      <= '0;
      wrPtr      <= '0;
      fetchPc    <= RST_PC;
      fetchCount <= '0;
    end else if (redirect) begin
      rdPtr   <= '0;
      wrPtr   <= '0;
      fetchPc <= redirect_pc;
    end else begin
      if (push) begin
        wrPtr   <= wrPtr + PTR_ONE;
        fetchPc <= fetchPc + PC_STEP;
        if (fetchCount != 16'hFFFF) fetchCount <= fetchCount + 16'd1;
      end
      if (pop) rdPtr <= rdPtr + PTR_ONE;
    end
  end

  assign imem_addr   = fetchPc;
  assign instr_valid = ~empty;
  assign instr_out   = instr_valid ? headEntry[WORD_W-1:0] : NOP_INSTR;
  assign instr_pc    = instr_valid ? headEntry[2*WORD_W-1:WORD_W] : '0;
  assign occupancy   = wrPtr - rdPtr;
  assign fetch_count = fetchCount;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: a queue-based reference model predicts every output each cycle.
// A second instance with RST_PC=16'hFFFE shares the control inputs to exercise PC wrap.
module tb_instr_prefetch_queue;
  localparam int          DEPTH   = 4;
  localparam logic [15:0] PC_STEP = 16'd1;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ready, redirect, dec_stall;
  logic [15:0] redirect_pc, salt;

  logic [15:0] imem_addr, imem_rdata, instr_out, instr_pc, fetch_count;
  logic        imem_req, instr_valid;
  logic [2:0]  occupancy;

  logic [15:0] imem_addr2, imem_rdata2, instr_out2, instr_pc2, fetch_count2;
  logic        imem_req2, instr_valid2;
  logic [2:0]  occupancy2;

  always #5 clk = ~clk;

  assign imem_rdata  = imem_addr + 16'h1000 + salt;
  assign imem_rdata2 = imem_addr2 + 16'h1000 + salt;

  instr_prefetch_queue #(.DEPTH(DEPTH), .PC_STEP(PC_STEP), .RST_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .dec_stall(dec_stall), .instr_valid(instr_valid),
    .instr_out(instr_out), .instr_pc(instr_pc), .occupancy(occupancy),
    .fetch_count(fetch_count));

  instr_prefetch_queue #(.DEPTH(DEPTH), .PC_STEP(PC_STEP), .RST_PC(16'hFFFE)) dut2 (
    .clk(clk), .reset(reset), .imem_addr(imem_addr2), .imem_req(imem_req2),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata2), .redirect(redirect),
    .redirect_pc(redirect_pc), .dec_stall(dec_stall), .instr_valid(instr_valid2),
    .instr_out(instr_out2), .instr_pc(instr_pc2), .occupancy(occupancy2),
    .fetch_count(fetch_count2));

  // Reference model: queue of {pc, instr}, next fetch PC and saturating fetch count.
  logic [31:0] mq[$];
  logic [15:0] mPc, mCnt;
  int checks = 0, passes = 0, cyc = 0;

  task automatic model_reset();
    mq.delete();
    mPc  = 16'h0000;
    mCnt = 16'h0000;
  endtask

  function automatic logic [68:0] expOut();
    logic v; logic [31:0] h; logic req;
    v   = (mq.size() > 0);
    h   = v ? mq[0] : 32'h0;
    req = !redirect && ((mq.size() < DEPTH) || (v && !dec_stall));
    return {v, h[15:0], h[31:16], 3'(mq.size()), req, mPc, mCnt};
  endfunction

  function automatic logic [68:0] obsOut();
    return {instr_valid, instr_out, instr_pc, occupancy, imem_req, imem_addr, fetch_count};
  endfunction

  // Same push/pop history as the main instance, all PCs offset by 16'hFFFE.
  function automatic logic [68:0] expOut2();
    logic [68:0] e;
    e = expOut();
    if (e[68]) begin
      e[67:52] = e[67:52] + 16'hFFFE;
      e[51:36] = e[51:36] + 16'hFFFE;
    end
    e[31:16] = e[31:16] + 16'hFFFE;
    return e;
  endfunction

  function automatic logic [68:0] obsOut2();
    return {instr_valid2, instr_out2, instr_pc2, occupancy2, imem_req2, imem_addr2, fetch_count2};
  endfunction

  task automatic drive(input logic r, input logic [15:0] rpc, input logic st, input logic rdy);
    redirect    = r;
    redirect_pc = rpc;
    dec_stall   = st;
    imem_ready  = rdy;
  endtask

  task automatic tick();
    logic pop, req, push;
    logic [31:0] entry;
    @(posedge clk);
    if (reset) model_reset();
    else if (redirect) begin
      mq.delete();
      mPc = redirect_pc;
    end else begin
      pop   = (mq.size() > 0) && !dec_stall;
      req   = (mq.size() < DEPTH) || pop;
      push  = req && imem_ready;
      entry = {mPc, mPc + 16'h1000 + salt};
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(entry);
        mPc = mPc + PC_STEP;
        if (mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    salt  = 16'h0;
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    model_reset();
    #1;
    checks++;
    if (obsOut() !== expOut()) $display("FAIL reset_state got %h expected %h", obsOut(), expOut());
    else passes++;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000)
      $display("FAIL reset_first_req got req=%b addr=%h expected req=1 addr=0000", imem_req, imem_addr);
    else passes++;
    tick();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 16'h0, 1'b0, 1'b1);
      #1;
      checks++;
      if (obsOut() !== expOut()) $display("FAIL stream c%0d got %h expected %h", cyc, obsOut(), expOut());
      else passes++;
      tick();
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 16'h0, (i < 8), 1'b1);
      #1;
      checks++;
      if (obsOut() !== expOut()) $display("FAIL stall c%0d got %h expected %h", cyc, obsOut(), expOut());
      else passes++;
      tick();
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 16'h0, 1'b1, 1'b1);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 16'h0, 1'b0, 1'b1);
      #1;
      checks++;
      if (obsOut() !== expOut() || occupancy !== 3'(DEPTH))
        $display("FAIL full_push_pop c%0d got %h expected %h", cyc, obsOut(), expOut());
      else passes++;
      tick();
    end
  endtask

  task automatic test_redirect();
    drive(1'b1, 16'h0100, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'h0, 1'b1, 1'b1);
      tick();
    end
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    #1;
    checks++;
    if (occupancy !== 3'd3) $display("FAIL redirect_prefill got %0d expected 3", occupancy);
    else passes++;
    drive(1'b1, 16'h0040, 1'b1, 1'b1);
    tick();
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    #1;
    checks++;
    if (instr_valid !== 1'b0 || obsOut() !== expOut())
      $display("FAIL redirect_bubble got %h expected %h", obsOut(), expOut());
    else passes++;
    tick();
    #1;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0040 || instr_out !== 16'h1040)
      $display("FAIL redirect_target got v=%b pc=%h instr=%h expected v=1 pc=0040 instr=1040",
               instr_valid, instr_pc, instr_out);
    else passes++;
    tick();
    drive(1'b1, 16'h0200, 1'b0, 1'b1); tick();
    drive(1'b1, 16'h0300, 1'b1, 1'b1); tick();
    drive(1'b1, 16'h0080, 1'b0, 1'b1);
    #1;
    checks++;
    if (obsOut() !== expOut()) $display("FAIL redirect_repeat got %h expected %h", obsOut(), expOut());
    else passes++;
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 16'h0, 1'b0, 1'b1);
      #1;
      checks++;
      if (obsOut() !== expOut()) $display("FAIL redirect_resume c%0d got %h expected %h", cyc, obsOut(), expOut());
      else passes++;
      tick();
    end
  endtask

  task automatic test_pc_wrap();
    logic        rdyPat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [15:0] wantPc [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    logic [15:0] seen[$];
    salt  = 16'h0;
    reset = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 16'h0, 1'b0, rdyPat[i]);
      #1;
      checks++;
      if (obsOut2() !== expOut2() || obsOut() !== expOut())
        $display("FAIL pc_wrap c%0d got %h expected %h", cyc, obsOut2(), expOut2());
      else passes++;
      if (instr_valid2) seen.push_back(instr_pc2);
      tick();
    end
    checks++;
    if (seen.size() < 4 || seen[0] !== wantPc[0] || seen[1] !== wantPc[1] ||
        seen[2] !== wantPc[2] || seen[3] !== wantPc[3])
      $display("FAIL pc_wrap_order got %0d pops first=%h expected FFFE FFFF 0000 0001",
               seen.size(), (seen.size() > 0) ? seen[0] : 16'hxxxx);
    else passes++;
    checks++;
    if (fetch_count2 !== mCnt) $display("FAIL pc_wrap_count got %0d expected %0d", fetch_count2, mCnt);
    else passes++;
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 16'h0500, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'h0, 1'b1, 1'b1);
      tick();
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obsOut() !== expOut() || instr_valid !== 1'b0 || fetch_count !== 16'h0)
      $display("FAIL reset_mid got %h expected %h", obsOut(), expOut());
    else passes++;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 16'h0, 1'b0, 1'b1);
      #1;
      checks++;
      if (obsOut() !== expOut()) $display("FAIL reset_resume c%0d got %h expected %h", cyc, obsOut(), expOut());
      else passes++;
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      salt = 16'($urandom);
      drive(($urandom_range(15, 0) == 0), 16'($urandom), ($urandom_range(2, 0) == 0),
            ($urandom_range(3, 0) != 0));
      #1;
      checks++;
      if (obsOut() !== expOut()) $display("FAIL random c%0d got %h expected %h", cyc, obsOut(), expOut());
      else passes++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_full_push_pop();
    test_redirect();
    test_pc_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
